seq_booth_multiplier: RTL and testbench
=======================================

SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width; even, at least 4.
REQ-002 The block SHALL have parameter PW, fixed at 2*WIDTH: product width.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input in_valid, 1 bit: operands and mode are valid.
REQ-006 The block SHALL have output in_ready, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have inputs A and B, WIDTH bits each: multiplicand and multiplier.
REQ-008 The block SHALL have input signed_mode, 1 bit: 1 selects two's-complement operands, 0 selects unsigned operands.
REQ-009 The block SHALL have output out_valid, 1 bit: product is valid.
REQ-010 The block SHALL have input out_ready, 1 bit: the consumer takes the product.
REQ-011 The block SHALL have output product, PW bits: the result, two's-complement when signed_mode was 1.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; an acceptance occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-014 On acceptance, the block SHALL capture A, B and signed_mode, then extend both operands to WIDTH+2 bits (sign-extend when signed_mode=1, zero-extend otherwise), clear the accumulator and iteration counter, and enter BUSY.
REQ-015 In BUSY, the block SHALL retire one radix-4 Booth digit per cycle from the extended multiplier, LSB group first, using digits {-2,-1,0,+1,+2} times the extended multiplicand, added to the accumulator at weight 4^i.
REQ-016 BUSY SHALL last exactly N = WIDTH/2+1 cycles (9 for WIDTH=16); after the Nth iteration edge the FSM SHALL enter DONE.
REQ-017 In DONE, the block SHALL hold out_valid=1 and product equal to the low PW bits of the exact mathematical product; product SHALL stay stable until the handshake completes.
REQ-018 On the edge where out_valid=1 and out_ready=1, the FSM SHALL enter IDLE and out_valid SHALL fall.
REQ-019 The required latency is: acceptance at edge E makes out_valid 1 immediately after edge E+N.
REQ-020 Changes on A, B, signed_mode or in_valid during BUSY or DONE SHALL have no effect.
REQ-021 out_ready held 1 before DONE SHALL complete the handshake on the first DONE cycle, giving DONE a minimum length of one cycle.
REQ-022 The product SHALL be exact for all operand pairs, including signed -2^(W-1) * -2^(W-1) and unsigned (2^W-1) * (2^W-1).
REQ-023 The product register SHALL update only in DONE-entry and reset; it SHALL NOT show intermediate accumulator values.

Reset
REQ-024 rst_n=0 SHALL force, asynchronously: state IDLE, in_ready=1 after release, out_valid=0, product=0, counter=0, accumulator=0.
REQ-025 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation with no partial result ever presented; the first acceptance after release SHALL behave as from power-up.

Structure
REQ-026 A shared package mult_pkg SHALL hold the FSM state encodings and the Booth digit-select codes (ZERO, POS1, POS2, NEG1, NEG2).
REQ-027 A combinational sub-module booth_r4_encoder SHALL map a 3-bit multiplier group to a digit-select code; the datapath SHALL instantiate exactly one.
REQ-028 Iteration count SHALL be derived from WIDTH, with the counter width set to $clog2(N+1).

Verification (WIDTH=16)
REQ-029 Signed: A=0x0A00, B=0x0300, signed_mode=1 -> product=0x001E0000, out_valid exactly 9 cycles after acceptance.
REQ-030 Signed and unsigned modes SHALL be covered as follows:
- A=0xFF00, B=0x00FF, signed_mode=1 -> product=0xFFFF0100.
- Same operands with signed_mode=0 -> product=0x00FE0100.
REQ-031 Corner cases SHALL be covered as follows:
- A=B=0x8000, signed_mode=1 -> product=0x40000000.
- A=B=0xFFFF, signed_mode=0 -> product=0xFFFE0001.
- A=0x00D0, B=0xA000, signed_mode=1 -> product=0xFFB20000.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> product and out_valid stay stable and in_ready stays 0; in_valid pulses meanwhile are ignored; out_ready=1 -> IDLE on the next edge.
REQ-033 Reset mid-operation: drop rst_n on BUSY cycle 4 -> out_valid=0 and product=0 immediately; after release, A=1, B=0 -> product=0.
REQ-034 Randomised sweep: 10k random A, B and mode against a reference model, with random in_valid and out_ready gaps.

Source files
------------

// File: rtl/seq_booth_multiplier_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit-select codes and the group-to-digit mapping.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } digit_e;

   // grp = {b[2i+1], b[2i], b[2i-1]}
   function automatic digit_e booth_digit(input logic [2:0] grp);
      digit_e d;
      case (grp)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seq_booth_multiplier_enc.sv
// Combinational radix-4 Booth encoder: 3-bit multiplier group to digit code.
module booth_r4_encoder
   import mult_pkg::*;
(
   input  logic [2:0] grp,
   output digit_e     digit
);

   always_comb begin
      digit = booth_digit(grp);
   end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, WIDTH/2+1 cycles,
// signed or unsigned operands, valid/ready handshakes on both sides.
module seq_booth_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int PW    = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW-1:0]    product
);

   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);
   localparam int XW = WIDTH + 2;

   state_e          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   mcand;
   logic [XW:0]     mplier;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   acc_sum;
   logic            accept;
   logic            last_iter;
   digit_e          digit;

   booth_r4_encoder u_enc (
      .grp   (mplier[2:0]),
      .digit (digit)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE);
   assign last_iter = (cnt == CW'(N - 1));

   // Arithmetic is modulo 2^PW; the low PW bits of the exact product are all
   // that is kept, so the multiplicand is pre-extended and shifted in place.
   always_comb begin
      pp = '0;
      case (digit)
         POS1:    pp = mcand;
         POS2:    pp = mcand << 1;
         NEG1:    pp = -mcand;
         NEG2:    pp = -(mcand << 1);
         default: pp = '0;
      endcase
      acc_sum = acc + pp;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last_iter) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else if (accept) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{(PW-WIDTH){A[WIDTH-1] & signed_mode}}, A};
         mplier <= {{2{B[WIDTH-1] & signed_mode}}, B, 1'b0};
      end else if (state == BUSY) begin
         cnt    <= cnt + 1'b1;
         acc    <= acc_sum;
         mcand  <= mcand << 2;
         mplier <= {{2{mplier[XW]}}, mplier[XW:2]};
         if (last_iter) begin
            product <= acc_sum;
         end
      end
   end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed checks for seq_booth_multiplier (WIDTH=16) with a small random sweep.
module tb_seq_booth_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_prod;

   seq_booth_multiplier #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .product     (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic sm);
      longint sa, sb, p;
      sa = sm ? longint'($signed(a)) : longint'(a);
      sb = sm ? longint'($signed(b)) : longint'(b);
      p  = sa * sb;
      return p[31:0];
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, then scramble inputs while it runs.
   task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic sm);
      int n = 0;
      while (!in_ready && n < 50) begin
         cycle();
         n++;
      end
      chk("accept_ready", {63'd0, in_ready}, 64'd1);
      in_valid    = 1'b1;
      A           = a;
      B           = b;
      signed_mode = sm;
      cycle();
      in_valid    = 1'b0;
      A           = 16'($urandom);
      B           = 16'($urandom);
      signed_mode = 1'($urandom);
   endtask

   // Wait for DONE, checking the product register never moves while busy.
   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      do begin
         cycle();
         lat++;
         if (!out_valid) begin
            chk({tag, "_hold_busy"}, {32'd0, product}, {32'd0, last_prod});
            in_valid = 1'($urandom);
         end
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
   endtask

   // Full operation; drain_delay cycles of out_ready=0 in DONE before taking it.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input logic [31:0] exp, input int drain_delay);
      int lat;
      out_ready = (drain_delay == 0);
      accept_op(a, b, sm);
      wait_done(tag, lat);
      chk({tag, "_latency"}, 64'(lat), 64'd9);
      chk({tag, "_product"}, {32'd0, product}, {32'd0, exp});
      for (int i = 0; i < drain_delay; i++) begin
         in_valid = 1'b1;
         cycle();
         chk({tag, "_bp_valid"}, {63'd0, out_valid}, 64'd1);
         chk({tag, "_bp_product"}, {32'd0, product}, {32'd0, exp});
         chk({tag, "_bp_inready"}, {63'd0, in_ready}, 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle();
      chk({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_drain_ready"}, {63'd0, in_ready}, 64'd1);
      last_prod = exp;
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rs;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      A           = '0;
      B           = '0;
      signed_mode = 1'b0;
      out_ready   = 1'b1;
      last_prod   = '0;

      repeat (3) cycle();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_product", {32'd0, product}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      rst_n = 1'b1;
      cycle();

      run_op("sgn_basic",   16'h0A00, 16'h0300, 1'b1, 32'h001E0000, 0);
      run_op("sgn_mixed",   16'hFF00, 16'h00FF, 1'b1, 32'hFFFF0100, 0);
      run_op("uns_mixed",   16'hFF00, 16'h00FF, 1'b0, 32'h00FE0100, 0);
      run_op("sgn_minmin",  16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
      run_op("uns_maxmax",  16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);
      run_op("sgn_neg",     16'h00D0, 16'hA000, 1'b1, 32'hFFB20000, 0);
      run_op("sgn_m1m1",    16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 0);
      run_op("backpress",   16'h1234, 16'h5678, 1'b0, 32'h06260060, 5);

      // Abort mid-BUSY: outputs clear at once, next op is clean.
      out_ready = 1'b1;
      accept_op(16'h7FFF, 16'h7FFF, 1'b1);
      chk("abort_busy_ready", {63'd0, in_ready}, 64'd0);
      repeat (3) cycle();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
      chk("abort_product", {32'd0, product}, 64'd0);
      chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
      cycle();
      rst_n     = 1'b1;
      last_prod = '0;
      cycle();
      run_op("post_rst", 16'h0001, 16'h0000, 1'b1, 32'h00000000, 0);

      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         repeat ($urandom_range(0, 3)) cycle();
         run_op("rand", ra, rb, rs, ref_mul(ra, rb, rs), int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
